// File: rtl/alu_frame_pkg.sv
// Shared types and constants for the framed ALU command decoder.
package alu_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_OP,
        S_GET_A,
        S_GET_B,
        S_GET_CHK,
        S_EXEC,
        S_SEND_STAT,
        S_SEND_RES
    } frame_state_e;

    localparam int unsigned NB_STATUS = 8;

    localparam logic [NB_STATUS-1:0] ST_OK      = 8'h00;
    localparam logic [NB_STATUS-1:0] ST_CHK     = 8'h01;
    localparam logic [NB_STATUS-1:0] ST_TIMEOUT = 8'h02;
    localparam logic [NB_STATUS-1:0] ST_BADOP   = 8'h03;

    localparam logic [7:0] DEFAULT_SOF = 8'hA5;

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte idle counter for a frame in progress; built only when
// ALU_FRAME_TIMEOUT_EN is defined.
`ifdef ALU_FRAME_TIMEOUT_EN
module frame_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned NB_TIMEOUT     = 20
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    logic [NB_TIMEOUT-1:0] cnt_q;

    // Saturates at the expiry value so a stalled enable cannot wrap.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else if (i_clear) begin
            cnt_q <= '0;
        end else if (i_enable && !o_expired_c) begin
            cnt_q <= cnt_q + NB_TIMEOUT'(1);
        end
    end

    assign o_expired_c = (cnt_q == NB_TIMEOUT'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/alu_cmd_framer.sv
// Framed command decoder between UART FIFOs and the ALU: SOF, opcode, A, B, checksum in;
// status, result out. Optional inter-byte timeout under ALU_FRAME_TIMEOUT_EN.
module alu_cmd_framer
    import alu_frame_pkg::*;
#(
    parameter int unsigned         NB_DATA        = 8,
    parameter int unsigned         NB_OPCODE      = 6,
    parameter logic [NB_DATA-1:0]  SOF_BYTE       = NB_DATA'(DEFAULT_SOF),
    parameter int unsigned         TIMEOUT_CYCLES = 1000000,
    parameter int unsigned         NB_TIMEOUT     = 20
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NB_DATA-1:0]   i_rx_data,
    input  logic                 i_rx_empty,
    input  logic                 i_tx_full,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic                 o_rx_read,
    output logic                 o_tx_write,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic [NB_OPCODE-1:0] o_alu_opcode,
    output logic [NB_DATA-1:0]   o_alu_op_A,
    output logic [NB_DATA-1:0]   o_alu_op_B,
    output logic                 o_frame_ok,
    output logic                 o_frame_err
);

    frame_state_e         state_q;
    logic [NB_DATA-1:0]   op_q, a_q, b_q;
    logic [NB_OPCODE-1:0] alu_opc_q;
    logic [NB_DATA-1:0]   alu_a_q, alu_b_q;
    logic [NB_DATA-1:0]   status_q, result_q;
    logic                 ok_q, err_q;
    logic                 in_frame_c, tmo_expired;

    assign in_frame_c = (state_q == S_GET_OP) || (state_q == S_GET_A) ||
                        (state_q == S_GET_B)  || (state_q == S_GET_CHK);

    // FIFO handshakes are combinational so a byte moves in the same cycle it is accepted.
    assign o_rx_read  = (in_frame_c || (state_q == S_IDLE)) && !i_rx_empty;
    assign o_tx_write = ((state_q == S_SEND_STAT) || (state_q == S_SEND_RES)) && !i_tx_full;
    assign o_tx_data  = !o_tx_write              ? '0       :
                        (state_q == S_SEND_STAT) ? status_q : result_q;

`ifdef ALU_FRAME_TIMEOUT_EN
    frame_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .NB_TIMEOUT     (NB_TIMEOUT)
    ) u_timeout (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (!in_frame_c || o_rx_read),
        .i_enable    (in_frame_c),
        .o_expired_c (tmo_expired)
    );
`else
    // No counter in this build; sizing parameters stay for a uniform interface.
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^{TIMEOUT_CYCLES, NB_TIMEOUT};
    assign tmo_expired    = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_opc_q <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            status_q  <= '0;
            result_q  <= '0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ok_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (o_rx_read && (i_rx_data == SOF_BYTE)) state_q <= S_GET_OP;
                end
                S_GET_OP: begin
                    if (o_rx_read) begin
                        op_q    <= i_rx_data;
                        state_q <= S_GET_A;
                    end
                end
                S_GET_A: begin
                    if (o_rx_read) begin
                        a_q     <= i_rx_data;
                        state_q <= S_GET_B;
                    end
                end
                S_GET_B: begin
                    if (o_rx_read) begin
                        b_q     <= i_rx_data;
                        state_q <= S_GET_CHK;
                    end
                end
                S_GET_CHK: begin
                    // Checksum error takes precedence over an out-of-range opcode.
                    if (o_rx_read) begin
                        if ((op_q ^ a_q ^ b_q) != i_rx_data) begin
                            status_q <= NB_DATA'(ST_CHK);
                            result_q <= '0;
                            err_q    <= 1'b1;
                            state_q  <= S_SEND_STAT;
                        end else if (op_q[NB_DATA-1:NB_OPCODE] != '0) begin
                            status_q <= NB_DATA'(ST_BADOP);
                            result_q <= '0;
                            err_q    <= 1'b1;
                            state_q  <= S_SEND_STAT;
                        end else begin
                            alu_opc_q <= op_q[NB_OPCODE-1:0];
                            alu_a_q   <= a_q;
                            alu_b_q   <= b_q;
                            status_q  <= NB_DATA'(ST_OK);
                            state_q   <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    result_q <= i_alu_result;
                    ok_q     <= 1'b1;
                    state_q  <= S_SEND_STAT;
                end
                S_SEND_STAT: begin
                    if (!i_tx_full) state_q <= S_SEND_RES;
                end
                S_SEND_RES: begin
                    if (!i_tx_full) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // Idle timeout inside a frame abandons it with a timeout response.
            if (tmo_expired && in_frame_c && !o_rx_read) begin
                status_q <= NB_DATA'(ST_TIMEOUT);
                result_q <= '0;
                err_q    <= 1'b1;
                state_q  <= S_SEND_STAT;
            end
        end
    end

    assign o_alu_opcode = alu_opc_q;
    assign o_alu_op_A   = alu_a_q;
    assign o_alu_op_B   = alu_b_q;
    assign o_frame_ok   = ok_q;
    assign o_frame_err  = err_q;

endmodule
